// File: rtl/cpu_reg_package.sv
// Shared bus constants plus the register map and state type of the multiplier responder.
package cpu_reg_package;

  localparam int DATA_WIDTH       = 32;
  localparam int ADDRESS_WIDTH    = 32;

  // Multiplier responder window: five consecutive words.
  localparam int MUL_WINDOW_WORDS = 5;
  localparam logic [2:0] MUL_OP_A   = 3'd0;
  localparam logic [2:0] MUL_OP_B   = 3'd1;
  localparam logic [2:0] MUL_CTRL   = 3'd2;
  localparam logic [2:0] MUL_RES_LO = 3'd3;
  localparam logic [2:0] MUL_RES_HI = 3'd4;

  // CTRL write bits.
  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_CLR_ERR_BIT = 1;

  // STATUS read bits.
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

  // One shift-add step per multiplier bit.
  localparam int MUL_STEPS   = DATA_WIDTH;
  localparam int MUL_COUNT_W = $clog2(MUL_STEPS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mul_state_t;

endpackage

// File: rtl/shift_add_mul_core.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per cycle, 64-bit accumulator.
module shift_add_mul_core
  import cpu_reg_package::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    load,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic                    run,
  output logic                    result_valid,
  output logic [2*DATA_WIDTH-1:0] product
);

  mul_state_t                 state_reg, state_next;
  logic [MUL_COUNT_W-1:0]     count_reg;
  logic [2*DATA_WIDTH-1:0]    acc_reg;
  logic [2*DATA_WIDTH-1:0]    mcand_reg;
  logic [DATA_WIDTH-1:0]      mplr_reg;
  logic [2*DATA_WIDTH-1:0]    step_sum;

  // Accumulator value after the current step; on the last step this is the full product.
  assign step_sum     = acc_reg + (mplr_reg[0] ? mcand_reg : '0);
  assign run          = (state_reg == RUN);
  assign result_valid = run && (count_reg == MUL_COUNT_W'(1));
  assign product      = step_sum;

  // State register; soft clear aborts a running multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state_reg <= IDLE;
    else if (clear) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  // Next-state logic: start from IDLE, leave RUN on the final step.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load) state_next = RUN;
      RUN:     if (count_reg == MUL_COUNT_W'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on start, then shift multiplicand left and multiplier right each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      acc_reg   <= '0;
      mcand_reg <= '0;
      mplr_reg  <= '0;
    end else if (clear) begin
      count_reg <= '0;
      acc_reg   <= '0;
      mcand_reg <= '0;
      mplr_reg  <= '0;
    end else if (state_reg == IDLE && load) begin
      count_reg <= MUL_COUNT_W'(MUL_STEPS);
      acc_reg   <= '0;
      mcand_reg <= {{DATA_WIDTH{1'b0}}, op_a};
      mplr_reg  <= op_b;
    end else if (state_reg == RUN) begin
      count_reg <= count_reg - MUL_COUNT_W'(1);
      acc_reg   <= step_sum;
      mcand_reg <= mcand_reg << 1;
      mplr_reg  <= mplr_reg >> 1;
    end
  end

endmodule

// File: rtl/cdc_mul_responder.sv
// Bus responder for one CDC entry: operand/result register file, error/done flags and
// an OR-combinable registered read port in front of a sequential multiplier.
module cdc_mul_responder
  import cpu_reg_package::*;
#(
  parameter logic [ADDRESS_WIDTH-1:0] base_address = '0,
  parameter bit                       busy_en      = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cpu_reset_i,
  input  logic [ADDRESS_WIDTH-1:0] address_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic                     we_i,
  output logic [DATA_WIDTH-1:0]    data_o,
  output logic                     busy_o
);

  logic [ADDRESS_WIDTH-1:0]  offset;
  logic                      in_window;
  logic [2:0]                sel;
  logic                      wr_hit;
  logic                      start;
  logic                      err_set;
  logic                      err_clr;
  logic                      run;
  logic                      result_valid;
  logic [2*DATA_WIDTH-1:0]   product;
  logic [DATA_WIDTH-1:0]     op_a_reg;
  logic [DATA_WIDTH-1:0]     op_b_reg;
  logic [2*DATA_WIDTH-1:0]   result_reg;
  logic                      done_reg;
  logic                      err_reg;
  logic [DATA_WIDTH-1:0]     status_word;
  logic [DATA_WIDTH-1:0]     read_next;

  // Unsigned subtract-and-compare also rejects addresses below the base.
  assign offset    = address_i - base_address;
  assign in_window = offset < ADDRESS_WIDTH'(MUL_WINDOW_WORDS);
  assign sel       = offset[2:0];
  assign wr_hit    = we_i && in_window;

  // Write decode: start only from IDLE; writable registers touched while running flag an error.
  always_comb begin
    start   = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
    if (wr_hit) begin
      if (sel == MUL_CTRL) begin
        start   = data_i[CTRL_START_BIT] && !run;
        err_clr = data_i[CTRL_CLR_ERR_BIT];
        err_set = run && (data_i[CTRL_START_BIT] || !data_i[CTRL_CLR_ERR_BIT]);
      end else if (sel == MUL_OP_A || sel == MUL_OP_B) begin
        err_set = run;
      end
    end
  end

  shift_add_mul_core u_core (
    .clk          (clk_i),
    .rst_n        (reset_i),
    .clear        (cpu_reset_i),
    .load         (start),
    .op_a         (op_a_reg),
    .op_b         (op_b_reg),
    .run          (run),
    .result_valid (result_valid),
    .product      (product)
  );

  // Read mux; everything outside the window reads as zero.
  always_comb begin
    status_word                = '0;
    status_word[STAT_BUSY_BIT] = run;
    status_word[STAT_DONE_BIT] = done_reg;
    status_word[STAT_ERR_BIT]  = err_reg;
    read_next                  = '0;
    if (in_window) begin
      case (sel)
        MUL_OP_A:   read_next = op_a_reg;
        MUL_OP_B:   read_next = op_b_reg;
        MUL_CTRL:   read_next = status_word;
        MUL_RES_LO: read_next = result_reg[DATA_WIDTH-1:0];
        MUL_RES_HI: read_next = result_reg[2*DATA_WIDTH-1:DATA_WIDTH];
        default:    read_next = '0;
      endcase
    end
  end

  // Register file, flags, busy and read data; both resets clear everything including RESULT.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      busy_o     <= 1'b0;
      data_o     <= '0;
    end else if (cpu_reset_i) begin
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      busy_o     <= 1'b0;
      data_o     <= '0;
    end else begin
      if (wr_hit && !run && sel == MUL_OP_A) op_a_reg <= data_i;
      if (wr_hit && !run && sel == MUL_OP_B) op_b_reg <= data_i;
      if (result_valid) result_reg <= product;
      if (start)             done_reg <= 1'b0;
      else if (result_valid) done_reg <= 1'b1;
      if (err_clr)      err_reg <= 1'b0;
      else if (err_set) err_reg <= 1'b1;
      busy_o <= busy_en & run;
      data_o <= read_next;
    end
  end

endmodule

// File: tb/tb_cdc_mul_responder.sv
// Bench for cdc_mul_responder: two responders on one bus (busy enabled / disabled),
// read expectations queued when a read is issued and checked when data_o returns.
module tb_cdc_mul_responder;
  import cpu_reg_package::*;

  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'h0000_0100;
  localparam logic [31:0] IDLE_ADDR = 32'h0000_0200;

  logic        clk;
  logic        reset_i;
  logic        cpu_reset_i;
  logic [31:0] address_i;
  logic [31:0] data_i;
  logic        we_i;
  logic [31:0] data_o_a, data_o_b, rd_bus;
  logic        busy_o_a, busy_o_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  cdc_mul_responder #(.base_address(BASE_A), .busy_en(1'b1)) dut_a (
    .clk_i(clk), .reset_i(reset_i), .cpu_reset_i(cpu_reset_i), .address_i(address_i),
    .data_i(data_i), .we_i(we_i), .data_o(data_o_a), .busy_o(busy_o_a));

  cdc_mul_responder #(.base_address(BASE_B), .busy_en(1'b0)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .cpu_reset_i(cpu_reset_i), .address_i(address_i),
    .data_i(data_i), .we_i(we_i), .data_o(data_o_b), .busy_o(busy_o_b));

  // Out-of-window responders read zero, so the bus is a plain OR.
  assign rd_bus = data_o_a | data_o_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    address_i = addr;
    data_i    = data;
    we_i      = 1'b1;
    tick();
    we_i      = 1'b0;
    address_i = IDLE_ADDR;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    address_i = addr;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    address_i = IDLE_ADDR;
    begin
      logic [31:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {32'd0, rd_bus}, {32'd0, e});
    end
  endtask

  task automatic read_all_zero(input logic [31:0] base, input string tag);
    for (int i = 0; i < 5; i++) bus_read(base + 32'(i), 32'd0, $sformatf("%s_off%0d", tag, i));
  endtask

  task automatic read_result(input logic [31:0] base, input logic [63:0] exp, input string tag);
    bus_read(base + 32'd3, exp[31:0],  {tag, "_lo"});
    bus_read(base + 32'd4, exp[63:32], {tag, "_hi"});
  endtask

  initial begin
    logic [31:0] a1, b1, a2, b2;
    int          busy_cnt, first_hi, last_hi, busy_b_hi;

    reset_i     = 1'b0;
    cpu_reset_i = 1'b0;
    address_i   = IDLE_ADDR;
    data_i      = '0;
    we_i        = 1'b0;
    ticks(3);
    #2 reset_i = 1'b1;
    tick();

    // 1: reset state and out-of-window reads
    read_all_zero(BASE_A, "rst_a");
    check("rst_busy", {63'd0, busy_o_a}, 64'd0);
    bus_read(BASE_A + 32'd5, 32'd0, "out_of_window");

    // 2: 3*5 with busy timing
    bus_write(BASE_A + 0, 32'd3);
    bus_write(BASE_A + 1, 32'd5);
    bus_write(BASE_A + 2, 32'h1);                 // sampled at edge E
    check("busy_at_E", {63'd0, busy_o_a}, 64'd0);
    busy_cnt = 0; first_hi = 0; last_hi = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (busy_o_a) begin
        busy_cnt++;
        if (first_hi == 0) first_hi = i;
        last_hi = i;
      end
    end
    check("busy_cycles", 64'(busy_cnt), 64'd32);
    check("busy_first", 64'(first_hi), 64'd1);
    check("busy_last", 64'(last_hi), 64'd32);
    read_result(BASE_A, 64'd15, "mul3x5");
    bus_read(BASE_A + 2, 32'h2, "status_done");

    // 3: full-range operands
    bus_write(BASE_A + 0, 32'hFFFF_FFFF);
    bus_write(BASE_A + 1, 32'hFFFF_FFFF);
    bus_write(BASE_A + 2, 32'h1);
    ticks(34);
    read_result(BASE_A, 64'hFFFF_FFFE_0000_0001, "mul_max");

    // back-to-back starts with random operands; second start right after completion
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    bus_write(BASE_A + 0, a1);
    bus_write(BASE_A + 1, b1);
    bus_write(BASE_A + 2, 32'h1);                 // edge E
    ticks(32);                                    // now just after E+32
    check("b2b_first_done", {32'd0, dut_a.u_core.run ? 32'd1 : 32'd0}, 64'd0);
    bus_write(BASE_A + 2, 32'h1);                 // restart at E+33, same operands
    bus_read(BASE_A + 2, 32'h1, "b2b_done_cleared");
    ticks(34);
    read_result(BASE_A, {32'd0, a1} * {32'd0, b1}, "mul_rand1");
    bus_write(BASE_A + 0, a2);
    bus_write(BASE_A + 1, b2);
    bus_write(BASE_A + 2, 32'h1);
    ticks(34);
    read_result(BASE_A, {32'd0, a2} * {32'd0, b2}, "mul_rand2");

    // zero operand still runs the full length
    bus_write(BASE_A + 0, 32'd0);
    bus_write(BASE_A + 2, 32'h1);
    ticks(31);
    check("zero_op_busy", {63'd0, busy_o_a}, 64'd1);
    ticks(3);
    read_result(BASE_A, 64'd0, "mul_zero");

    // 4: writes during RUN
    bus_write(BASE_A + 0, 32'd9);
    bus_write(BASE_A + 1, 32'd11);
    bus_write(BASE_A + 2, 32'h1);                 // edge E
    bus_write(BASE_A + 3, 32'hDEAD_BEEF);         // read-only, no error
    bus_read(BASE_A + 2, 32'h1, "ro_write_no_err");
    ticks(7);
    bus_write(BASE_A + 0, 32'd7);                 // sampled at E+10
    bus_read(BASE_A + 2, 32'h5, "run_write_err");
    ticks(30);
    bus_read(BASE_A + 0, 32'd9, "op_a_kept");
    read_result(BASE_A, 64'd99, "mul9x11");
    bus_write(BASE_A + 2, 32'h2);
    bus_read(BASE_A + 2, 32'h2, "err_cleared");

    // 5a: soft reset mid-run
    bus_write(BASE_A + 0, 32'd3);
    bus_write(BASE_A + 1, 32'd5);
    bus_write(BASE_A + 2, 32'h1);                 // edge E
    ticks(4);
    cpu_reset_i = 1'b1;
    tick();                                       // sampled at E+5
    cpu_reset_i = 1'b0;
    check("soft_rst_busy", {63'd0, busy_o_a}, 64'd0);
    read_all_zero(BASE_A, "soft_rst");

    // 5b: async reset mid-run
    bus_write(BASE_A + 0, 32'd3);
    bus_write(BASE_A + 1, 32'd5);
    bus_write(BASE_A + 2, 32'h1);
    ticks(5);
    check("pre_async_busy", {63'd0, busy_o_a}, 64'd1);
    #2 reset_i = 1'b0;
    #1 check("async_rst_busy", {63'd0, busy_o_a}, 64'd0);
    tick();
    #2 reset_i = 1'b1;
    tick();
    read_all_zero(BASE_A, "async_rst");

    // 6: busy disabled responder
    bus_write(BASE_B + 0, 32'd3);
    bus_write(BASE_B + 1, 32'd5);
    bus_write(BASE_B + 2, 32'h1);
    busy_b_hi = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (busy_o_b) busy_b_hi++;
    end
    bus_read(BASE_B + 2, 32'h1, "nobusy_status_run");
    for (int i = 0; i < 25; i++) begin
      tick();
      if (busy_o_b) busy_b_hi++;
    end
    check("nobusy_busy_o", 64'(busy_b_hi), 64'd0);
    read_result(BASE_B, 64'd15, "nobusy_mul");
    bus_read(BASE_B + 2, 32'h2, "nobusy_status_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
